// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bcd_convert_scheduler
// Purpose  : Round-robin shared 24-bit binary to 6-digit BCD double-dabble engine.
// Revision : 1.0  initial release
// ============================================================================
module bcd_convert_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                    axis_aclk,
    input  logic                    axis_resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [24*NUM_REQ-1:0]   req_binary,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic [23:0]             rsp_bcd,
    output logic                    rsp_overflow,
    output logic                    busy
);

    localparam logic [23:0] c_MAX_DEC   = 24'd999999;
    localparam logic [23:0] c_SATURATED = 24'h999999;
    localparam logic [4:0]  c_LAST_BIT  = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                state_q;
    logic [ID_WIDTH-1:0]   last_grant_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [23:0]           shift_q;
    logic [23:0]           digits_q;
    logic [23:0]           digits_d;
    logic [23:0]           digits_adj;
    logic [4:0]            cnt_q;
    logic                  ovf_q;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [23:0]           sel_value;

    // Search order starts just after the previous winner, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (state_q == ST_IDLE && axis_resetn) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!grant_found && req_valid[k] &&
                        k == (int'(last_grant_q) + i) % NUM_REQ) begin
                        grant_found = 1'b1;
                        grant_idx   = ID_WIDTH'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_value = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_found && grant_idx == ID_WIDTH'(k)) begin
                req_ready[k] = 1'b1;
                sel_value    = req_binary[24*k +: 24];
            end
        end
    end

    always_comb begin
        digits_adj = digits_q;
        for (int d = 0; d < 6; d++) begin
            if (digits_q[4*d +: 4] >= 4'd5) begin
                digits_adj[4*d +: 4] = digits_q[4*d +: 4] + 4'd3;
            end
        end
        digits_d = {digits_adj[22:0], shift_q[23]};
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            id_q         <= '0;
            shift_q      <= '0;
            digits_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_bcd      <= '0;
            rsp_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        shift_q      <= sel_value;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        digits_q     <= '0;
                        cnt_q        <= c_LAST_BIT;
                        ovf_q        <= (sel_value > c_MAX_DEC);
                        busy         <= 1'b1;
                        state_q      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    digits_q <= digits_d;
                    shift_q  <= {shift_q[22:0], 1'b0};
                    if (cnt_q == 5'd0) begin
                        // Overflowed inputs still run all 24 steps; result is saturated.
                        rsp_bcd      <= ovf_q ? c_SATURATED : digits_d;
                        rsp_id       <= id_q;
                        rsp_overflow <= ovf_q;
                        rsp_valid    <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
